// File: rtl/dm_abstract_regs_pkg.sv
// Debug-module types shared by the abstract-command register file: DMI request/response
// layouts, abstract-command register formats, error codes and DMI address map helpers.
package dm;

    localparam int unsigned DataCountMax   = 12;
    localparam int unsigned ProgBufSizeMax = 16;

    localparam logic [31:0] CmdErrMask = 32'h0000_0700;

    localparam logic [6:0] Data0        = 7'h04;
    localparam logic [6:0] AbstractCS   = 7'h16;
    localparam logic [6:0] Command      = 7'h17;
    localparam logic [6:0] AbstractAuto = 7'h18;
    localparam logic [6:0] ProgBuf0     = 7'h20;

    typedef enum logic [1:0] {
        DTM_NOP   = 2'h0,
        DTM_READ  = 2'h1,
        DTM_WRITE = 2'h2
    } dtm_op_e;

    typedef enum logic [1:0] {
        DTM_SUCCESS = 2'h0,
        DTM_ERR     = 2'h2,
        DTM_BUSY    = 2'h3
    } dtm_resp_e;

    typedef enum logic [2:0] {
        CmdErrNone         = 3'd0,
        CmdErrBusy         = 3'd1,
        CmdErrNotSupported = 3'd2,
        CmdErrorException  = 3'd3,
        CmdErrorHaltResume = 3'd4,
        CmdErrorBus        = 3'd5,
        CmdErrorOther      = 3'd7
    } cmderr_t;

    typedef struct packed {
        logic [6:0]  addr;
        dtm_op_e     op;
        logic [31:0] data;
    } dmi_req_t;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
    } dmi_resp_t;

    typedef struct packed {
        logic [2:0]  zero3;
        logic [4:0]  progbufsize;
        logic [10:0] zero2;
        logic        busy;
        logic        zero1;
        cmderr_t     cmderr;
        logic [3:0]  zero0;
        logic [3:0]  datacount;
    } abstractcs_t;

    typedef struct packed {
        logic [7:0]  cmdtype;
        logic [23:0] control;
    } command_t;

    typedef struct packed {
        logic [15:0] autoexecprogbuf;
        logic [3:0]  zero0;
        logic [11:0] autoexecdata;
    } abstractauto_t;

    // Last DMI address occupied by the data / program-buffer windows.
    function automatic logic [6:0] DataEnd(input int unsigned count);
        return 7'(32'(Data0) + count - 32'd1);
    endfunction

    function automatic logic [6:0] ProgBufEnd(input int unsigned count);
        return 7'(32'(ProgBuf0) + count - 32'd1);
    endfunction

endpackage

// File: rtl/dm_abstract_regs.sv
// DMI-visible abstract-command register file: data, progbuf, abstractcs, command and
// abstractauto, with busy/cmderr enforcement and command/autoexec triggering.
module dm_abstract_regs
    import dm::*;
#(
    parameter int unsigned DataCount   = 2,
    parameter int unsigned ProgBufSize = 8
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      dmactive_i,
    input  logic                      dmi_req_valid_i,
    output logic                      dmi_req_ready_o,
    input  dmi_req_t                  dmi_req_i,
    output logic                      dmi_resp_valid_o,
    input  logic                      dmi_resp_ready_i,
    output dmi_resp_t                 dmi_resp_o,
    output logic                      cmd_valid_o,
    output command_t                  cmd_o,
    input  logic                      cmdbusy_i,
    input  logic                      cmderror_valid_i,
    input  cmderr_t                   cmderror_i,
    output logic [32*DataCount-1:0]   data_o,
    output logic [32*ProgBufSize-1:0] progbuf_o,
    input  logic                      data_valid_i,
    input  logic [32*DataCount-1:0]   data_i
);

    localparam logic [6:0] DataLast    = DataEnd(DataCount);
    localparam logic [6:0] ProgBufLast = ProgBufEnd(ProgBufSize);

    logic [DataCount-1:0][31:0]   data_q, data_d;
    logic [ProgBufSize-1:0][31:0] progbuf_q, progbuf_d;
    logic [DataCount-1:0]         autodata_q, autodata_d;
    logic [ProgBufSize-1:0]       autoprog_q, autoprog_d;
    cmderr_t                      cmderr_q, cmderr_d;
    command_t                     command_q, command_d;
    logic                         cmd_valid_q, cmd_valid_d;
    logic                         resp_valid_q, resp_valid_d;
    logic [31:0]                  resp_data_q, resp_data_d;

    logic          accept, is_read, is_write;
    logic          data_sel, progbuf_sel, busy_viol, autoexec_hit;
    int unsigned   data_idx, progbuf_idx;
    logic [31:0]   rdata, w1c;
    abstractcs_t   acs_rd;
    abstractauto_t auto_rd;

    assign dmi_req_ready_o = !resp_valid_q || dmi_resp_ready_i;
    assign accept          = dmi_req_valid_i && dmi_req_ready_o;
    assign is_read         = accept && (dmi_req_i.op == DTM_READ);
    assign is_write        = accept && (dmi_req_i.op == DTM_WRITE);

    assign data_sel    = (dmi_req_i.addr >= Data0) && (dmi_req_i.addr <= DataLast);
    assign progbuf_sel = (dmi_req_i.addr >= ProgBuf0) && (dmi_req_i.addr <= ProgBufLast);
    assign data_idx    = 32'(dmi_req_i.addr) - 32'(Data0);
    assign progbuf_idx = 32'(dmi_req_i.addr) - 32'(ProgBuf0);
    assign w1c         = dmi_req_i.data & CmdErrMask;

    // Busy violations only cover accesses that could disturb a running command.
    assign busy_viol = cmdbusy_i &&
                       ((is_write && (data_sel || progbuf_sel ||
                                      dmi_req_i.addr == Command || dmi_req_i.addr == AbstractAuto)) ||
                        (is_read && (data_sel || progbuf_sel)));

    always_comb begin
        acs_rd             = '0;
        acs_rd.progbufsize = 5'(ProgBufSize);
        acs_rd.busy        = cmdbusy_i;
        acs_rd.cmderr      = cmderr_q;
        acs_rd.datacount   = 4'(DataCount);
        auto_rd            = '0;
        for (int unsigned i = 0; i < DataCount; i++) auto_rd.autoexecdata[i] = autodata_q[i];
        for (int unsigned j = 0; j < ProgBufSize; j++) auto_rd.autoexecprogbuf[j] = autoprog_q[j];

        rdata = '0;
        if (dmactive_i && dmi_req_i.op == DTM_READ) begin
            if (data_sel) begin
                if (!cmdbusy_i)
                    for (int unsigned i = 0; i < DataCount; i++)
                        if (data_idx == i) rdata = data_q[i];
            end else if (progbuf_sel) begin
                if (!cmdbusy_i)
                    for (int unsigned j = 0; j < ProgBufSize; j++)
                        if (progbuf_idx == j) rdata = progbuf_q[j];
            end else begin
                case (dmi_req_i.addr)
                    AbstractCS:   rdata = acs_rd;
                    Command:      rdata = command_q;
                    AbstractAuto: rdata = auto_rd;
                    default:      rdata = '0;
                endcase
            end
        end
    end

    always_comb begin
        autoexec_hit = 1'b0;
        for (int unsigned i = 0; i < DataCount; i++)
            if (data_sel && data_idx == i && autodata_q[i]) autoexec_hit = 1'b1;
        for (int unsigned j = 0; j < ProgBufSize; j++)
            if (progbuf_sel && progbuf_idx == j && autoprog_q[j]) autoexec_hit = 1'b1;
    end

    always_comb begin
        data_d      = data_q;
        progbuf_d   = progbuf_q;
        autodata_d  = autodata_q;
        autoprog_d  = autoprog_q;
        cmderr_d    = cmderr_q;
        command_d   = command_q;
        cmd_valid_d = 1'b0;

        if (!dmactive_i) begin
            data_d     = '0;
            progbuf_d  = '0;
            autodata_d = '0;
            autoprog_d = '0;
            cmderr_d   = CmdErrNone;
            command_d  = '0;
        end else begin
            if (is_write && dmi_req_i.addr == AbstractCS)
                cmderr_d = cmderr_t'(cmderr_q & ~w1c[10:8]);

            if (is_write && !cmdbusy_i) begin
                if (data_sel) begin
                    for (int unsigned i = 0; i < DataCount; i++)
                        if (data_idx == i) data_d[i] = dmi_req_i.data;
                end else if (progbuf_sel) begin
                    for (int unsigned j = 0; j < ProgBufSize; j++)
                        if (progbuf_idx == j) progbuf_d[j] = dmi_req_i.data;
                end else if (dmi_req_i.addr == Command) begin
                    command_d = command_t'(dmi_req_i.data);
                    if (cmderr_q == CmdErrNone) cmd_valid_d = 1'b1;
                end else if (dmi_req_i.addr == AbstractAuto) begin
                    for (int unsigned i = 0; i < DataCount; i++) autodata_d[i] = dmi_req_i.data[i];
                    for (int unsigned j = 0; j < ProgBufSize; j++) autoprog_d[j] = dmi_req_i.data[16+j];
                end
            end

            if ((is_read || is_write) && !cmdbusy_i && cmderr_q == CmdErrNone && autoexec_hit)
                cmd_valid_d = 1'b1;

            // Hart write-back overrides any DMI data write landing in the same cycle.
            if (data_valid_i) data_d = data_i;

            if (cmderr_q == CmdErrNone) begin
                if (cmderror_valid_i) cmderr_d = cmderror_i;
                else if (busy_viol)   cmderr_d = CmdErrBusy;
            end
        end
    end

    always_comb begin
        resp_valid_d = resp_valid_q;
        resp_data_d  = resp_data_q;
        if (accept) begin
            resp_valid_d = 1'b1;
            resp_data_d  = rdata;
        end else if (dmi_resp_ready_i) begin
            resp_valid_d = 1'b0;
            resp_data_d  = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            data_q       <= '0;
            progbuf_q    <= '0;
            autodata_q   <= '0;
            autoprog_q   <= '0;
            cmderr_q     <= CmdErrNone;
            command_q    <= '0;
            cmd_valid_q  <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
        end else begin
            data_q       <= data_d;
            progbuf_q    <= progbuf_d;
            autodata_q   <= autodata_d;
            autoprog_q   <= autoprog_d;
            cmderr_q     <= cmderr_d;
            command_q    <= command_d;
            cmd_valid_q  <= cmd_valid_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
        end
    end

    assign dmi_resp_valid_o = resp_valid_q;
    assign dmi_resp_o       = '{data: resp_data_q, resp: DTM_SUCCESS};
    assign cmd_valid_o      = cmd_valid_q;
    assign cmd_o            = command_q;
    assign data_o           = data_q;
    assign progbuf_o        = progbuf_q;

endmodule

// File: doc/dm_abstract_regs.md
# dm_abstract_regs

Parametrised abstract-command register file for the debug module, with configurable `DataCount` and `ProgBufSize`. It owns the DMI-visible registers `Data0..DataN-1`, `ProgBuf0..M-1`, `AbstractCS`, `Command` and `AbstractAuto`. It enforces the busy/cmderr rules and issues command and autoexec triggers to the abstract-command FSM. It sits between the DMI request path and the hart-side debug memory.

## Interface
- `DataCount`, default 2: number of data registers, legal range 1..12.
- `ProgBufSize`, default 8: number of program-buffer words, legal range 1..16.
- `clk_i`  in  1  the single clock.
- `rst_ni`  in  1  reset, synchronous and active-low.
- `dmactive_i`  in  1  while low, all state is held at reset values.
- `dmi_req_valid_i`  in  1  DMI request valid.
- `dmi_req_ready_o`  out  1  DMI request ready.
- `dmi_req_i`  in  41  `dm::dmi_req_t` (addr, op, data).
- `dmi_resp_valid_o`  out  1  DMI response valid.
- `dmi_resp_ready_i`  in  1  DMI response ready.
- `dmi_resp_o`  out  34  `dm::dmi_resp_t`.
- `cmd_valid_o`  out  1  single-cycle command-start pulse.
- `cmd_o`  out  32  `dm::command_t`, the latched command.
- `cmdbusy_i`  in  1  abstract-command FSM is busy.
- `cmderror_valid_i`  in  1  FSM reports an error.
- `cmderror_i`  in  3  `dm::cmderr_t`.
- `data_o`  out  `32*DataCount`  data registers, flattened, Data0 in the LSBs.
- `progbuf_o`  out  `32*ProgBufSize`  program buffer, flattened.
- `data_valid_i`  in  1  hart write-back strobe.
- `data_i`  in  `32*DataCount`  hart write-back values.

## Operation
- **Decode**
  - Addresses `0x04..0x04+DataCount-1` map to data.
  - Addresses `0x20..0x20+ProgBufSize-1` map to progbuf.
  - `0x16`, `0x17`, `0x18` map to AbstractCS, Command, AbstractAuto.
  - Any other address reads 0 and ignores writes.
  - `DTM_NOP` is accepted, returns 0 and has no side effect.
- **AbstractCS read:** `progbufsize=ProgBufSize`, `busy=cmdbusy_i`, `cmderr` from the register, `datacount=DataCount`, all other bits 0.
- **cmderr**
  - Writing AbstractCS clears each bit of `data[10:8]` written as 1 (W1C).
  - When cmderr is None, the first of the following events sets it:
    - a `cmderror_valid_i` report, which loads `cmderror_i`;
    - a busy violation, which loads Busy.
  - Priority between these: `cmderror_valid_i` wins over a busy violation, and both win over W1C in the same cycle.
- **Busy violation:** while `cmdbusy_i`=1, any write to data, progbuf, Command or AbstractAuto, or any read of data or progbuf:
  - is dropped (reads return 0);
  - sets cmderr=Busy if it is currently None;
  - never pulses `cmd_valid_o`.
- **Command write** (not busy): latch `cmd_o`. If cmderr=None, pulse `cmd_valid_o`. If cmderr is not None, latch only.
- **AbstractAuto**
  - `autoexecdata` bits at index `DataCount` and above read 0 (WARL).
  - `autoexecprogbuf` bits at index `ProgBufSize` and above read 0 (WARL).
- **Autoexec:** a non-busy read or write of data[i] with `autoexecdata[i]`=1 (same rule for progbuf[j] with `autoexecprogbuf[j]`=1), when cmderr=None, performs the access and then pulses `cmd_valid_o` with the unchanged `cmd_o`.
- **Hart write-back:** `data_valid_i` loads all data registers from `data_i`. It takes priority over a same-cycle DMI data write, which is dropped silently.
- **dmactive_i=0:**
  - all registers are held at reset values and `cmd_valid_o`=0;
  - requests are still accepted and answered with data 0;
  - writes are ignored.
- `resp` is always `DTM_SUCCESS`.

## Timing
- **Reset values:** `dmi_req_ready_o`=1, `dmi_resp_valid_o`=0, `dmi_resp_o`=0, `cmd_valid_o`=0, `cmd_o`=0, `data_o`=0, `progbuf_o`=0, cmderr=None, AbstractAuto=0.
- **Acceptance:** a request is accepted at cycle T when valid and ready are both 1.
  - Read data is sampled at T (pre-write value).
  - Register updates are visible at T+1.
  - `dmi_resp_valid_o`=1 from T+1.
  - `cmd_valid_o` is high for exactly cycle T+1.
- **Ready:** `dmi_req_ready_o` = `!dmi_resp_valid_o | dmi_resp_ready_i`.
  - Allows one request per cycle under a ready sink.
  - The response is held stable until taken.
- **Inputs:** `cmdbusy_i` and `cmderror_valid_i` are sampled at T.
- **Reset during a pending response:** the response is lost and outputs return to reset values on the next edge.

## Structure
- **Package additions to `dm`:**
  - `DataCountMax=12`, `ProgBufSizeMax=16`;
  - `DataEnd`/`ProgBufEnd` helper functions;
  - W1C mask constant `CmdErrMask=32'h700`.
- Reuse the existing `dmi_req_t`, `dmi_resp_t`, `abstractcs_t`, `command_t`, `abstractauto_t` and `cmderr_t`.
- No sub-module: a single flat module. The response register stays inline.

## Test plan
- **Data round-trip:** write `0xDEADBEEF` to `0x05` with DataCount=2, then read `0x05` → response `0xDEADBEEF`, `resp`=0. Reading `0x06` → 0.
- **Command issue:** write Command `0x00221001` while idle → `cmd_o`=`0x00221001` and `cmd_valid_o` is a single pulse at T+1. Read AbstractCS with ProgBufSize=8 → `0x08000002`.
- **Busy violation:** with `cmdbusy_i`=1, write data0 `0x1234` → data0 is unchanged and cmderr=1. A later Command write → no pulse. Writing AbstractCS `0x700` clears cmderr to 0.
- **Autoexec:** set AbstractAuto `0x00010001`, then read data0 and write progbuf0 on separate requests → one `cmd_valid_o` pulse each. Write AbstractAuto `0xFFFFFFFF` with DataCount=2, ProgBufSize=8 → reads back `0x00FF0003`.
- **Back-pressure:** hold `dmi_resp_ready_i`=0 for 5 cycles → `dmi_req_ready_o`=0 and the response is stable. With ready=1, back-to-back reads complete one per cycle.
- **Priority and reset:** `data_valid_i` and a DMI data0 write in the same cycle → data0 = hart value. `dmactive_i`=0 → all outputs 0 on the next edge. Synchronous `rst_ni`=0 with a response pending → `dmi_resp_valid_o`=0 on the next edge.
